// File: rtl/next_pc_unit_if.sv
// Decode-stage bundle between the control-transfer source and next_pc_unit.
// The master modport drives the decoded instruction; the slave modport is the PC owner.
interface next_pc_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             STALL;
    logic             VALID;
    logic [1:0]       BR_TYPE;
    logic [2:0]       FUNCT_THREE;
    logic [XLEN-1:0]  RS1;
    logic [XLEN-1:0]  RS2;
    logic [XLEN-1:0]  OFFSET;
    logic             TRAP_ACK;
    logic [XLEN-1:0]  PC;
    logic [XLEN-1:0]  LINK;
    logic             TAKEN;
    logic             FLUSH;
    logic             TRAP_PENDING;
    logic [XLEN-1:0]  EPC;
    logic [XLEN-1:0]  BADADDR;
    logic [CNT_W-1:0] TAKEN_COUNT;

    modport master (
        output STALL, VALID, BR_TYPE, FUNCT_THREE, RS1, RS2, OFFSET, TRAP_ACK,
        input  PC, LINK, TAKEN, FLUSH, TRAP_PENDING, EPC, BADADDR, TAKEN_COUNT
    );

    modport slave (
        input  STALL, VALID, BR_TYPE, FUNCT_THREE, RS1, RS2, OFFSET, TRAP_ACK,
        output PC, LINK, TAKEN, FLUSH, TRAP_PENDING, EPC, BADADDR, TAKEN_COUNT
    );
endinterface

// File: rtl/next_pc_unit.sv
// Next-PC / branch-resolution unit: owns the PC, resolves RV32I control transfers,
// traps misaligned targets and counts taken transfers.
module next_pc_unit #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int          CNT_W        = 16
) (
    input logic CLK,
    input logic RST_N,
    next_pc_unit_if.slave bus
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_e;

    localparam logic [XLEN-1:0]  RESET_VEC = XLEN'(RESET_VECTOR);
    localparam logic [XLEN-1:0]  TRAP_VEC  = XLEN'(TRAP_VECTOR);
    localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(32'd4);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  epc_q, epc_d;
    logic [XLEN-1:0]  badaddr_q, badaddr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             taken_q, taken_d;
    logic             flush_q, flush_d;
    logic             trap_pending_q, trap_pending_d;

    logic             xfer_s;
    logic [XLEN-1:0]  target_s;
    logic [XLEN-1:0]  jalr_sum_s;

    function automatic logic br_cond(input logic [2:0] f3,
                                     input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        logic r;
        case (f3)
            3'b000:  r = (a == b);
            3'b001:  r = (a != b);
            3'b100:  r = ($signed(a) < $signed(b));
            3'b101:  r = !($signed(a) < $signed(b));
            3'b110:  r = (a < b);
            3'b111:  r = !(a < b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Decode whether this instruction transfers control and where it goes.
    always_comb begin
        jalr_sum_s = bus.RS1 + bus.OFFSET;
        xfer_s     = 1'b0;
        target_s   = pc_q + bus.OFFSET;
        case (bus.BR_TYPE)
            2'b01: xfer_s = bus.VALID & br_cond(bus.FUNCT_THREE, bus.RS1, bus.RS2);
            2'b10: xfer_s = bus.VALID;
            2'b11: begin
                xfer_s   = bus.VALID;
                target_s = {jalr_sum_s[XLEN-1:1], 1'b0};
            end
            default: xfer_s = 1'b0;
        endcase
    end

    // Next-state logic for the RUN/TRAP machine and all architectural state.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        badaddr_d = badaddr_q;
        cnt_d     = cnt_q;
        taken_d   = 1'b0;
        flush_d   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!bus.STALL) begin
                    if (xfer_s) begin
                        if (target_s[1:0] == 2'b00) begin
                            pc_d    = target_s;
                            taken_d = 1'b1;
                            flush_d = 1'b1;
                            if (cnt_q != CNT_MAX) begin
                                cnt_d = cnt_q + CNT_ONE;
                            end else begin
                                cnt_d = cnt_q;
                            end
                        end else begin
                            // Misaligned target: enter the trap, nothing counted.
                            pc_d      = TRAP_VEC;
                            epc_d     = pc_q;
                            badaddr_d = target_s;
                            flush_d   = 1'b1;
                            state_d   = ST_TRAP;
                        end
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_TRAP: begin
                // Acknowledge is honoured regardless of STALL.
                if (bus.TRAP_ACK) begin
                    state_d = ST_RUN;
                    pc_d    = TRAP_VEC + PC_STEP;
                end else begin
                    pc_d = TRAP_VEC;
                end
            end
            default: begin
                state_d = ST_RUN;
                pc_d    = RESET_VEC;
            end
        endcase
        trap_pending_d = (state_d == ST_TRAP);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q        <= ST_RUN;
            pc_q           <= RESET_VEC;
            epc_q          <= '0;
            badaddr_q      <= '0;
            cnt_q          <= '0;
            taken_q        <= 1'b0;
            flush_q        <= 1'b0;
            trap_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            epc_q          <= epc_d;
            badaddr_q      <= badaddr_d;
            cnt_q          <= cnt_d;
            taken_q        <= taken_d;
            flush_q        <= flush_d;
            trap_pending_q <= trap_pending_d;
        end
    end

    assign bus.PC           = pc_q;
    assign bus.LINK         = pc_q + PC_STEP;
    assign bus.TAKEN        = taken_q;
    assign bus.FLUSH        = flush_q;
    assign bus.TRAP_PENDING = trap_pending_q;
    assign bus.EPC          = epc_q;
    assign bus.BADADDR      = badaddr_q;
    assign bus.TAKEN_COUNT  = cnt_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit with hand-computed expectations; a 2-bit
// counter is used so saturation shows up within a short run.
module tb_next_pc_unit;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    next_pc_unit_if #(.XLEN(32), .CNT_W(2)) bus ();

    next_pc_unit #(
        .XLEN(32),
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR(32'h0000_0100),
        .CNT_W(2)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] bt, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] off);
        bus.VALID       = v;
        bus.BR_TYPE     = bt;
        bus.FUNCT_THREE = f3;
        bus.RS1         = a;
        bus.RS2         = b;
        bus.OFFSET      = off;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input logic tk,
                             input logic fl, input logic tp, input logic [1:0] cnt);
        chk({tag, ".pc"}, bus.PC, pc);
        chk({tag, ".taken"}, {31'd0, bus.TAKEN}, {31'd0, tk});
        chk({tag, ".flush"}, {31'd0, bus.FLUSH}, {31'd0, fl});
        chk({tag, ".trap_pending"}, {31'd0, bus.TRAP_PENDING}, {31'd0, tp});
        chk({tag, ".count"}, {30'd0, bus.TAKEN_COUNT}, {30'd0, cnt});
    endtask

    initial begin
        bus.STALL    = 1'b0;
        bus.TRAP_ACK = 1'b0;
        drive(1'b0, 2'b00, 3'b000, 32'd0, 32'd0, 32'd0);

        // Reset values
        #3;
        chk_state("reset", 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("reset.epc", bus.EPC, 32'h0);
        chk("reset.badaddr", bus.BADADDR, 32'h0);
        chk("reset.link", bus.LINK, 32'h4);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        // Sequential fetch
        step(); chk_state("seq1", 32'h4, 1'b0, 1'b0, 1'b0, 2'd0);
        step(); chk_state("seq2", 32'h8, 1'b0, 1'b0, 1'b0, 2'd0);
        step(); chk_state("seq3", 32'hC, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 13; i++) step();
        chk("seq_to_40", bus.PC, 32'h40);

        // beq taken, then not taken
        drive(1'b1, 2'b01, 3'b000, 32'd5, 32'd5, 32'h20);
        step(); chk_state("beq_taken", 32'h60, 1'b1, 1'b1, 1'b0, 2'd1);
        drive(1'b0, 2'b00, 3'b000, 32'd0, 32'd0, 32'd0);
        step(); chk_state("after_beq", 32'h64, 1'b0, 1'b0, 1'b0, 2'd1);
        drive(1'b1, 2'b01, 3'b000, 32'd5, 32'd6, 32'h20);
        step(); chk_state("beq_not", 32'h68, 1'b0, 1'b0, 1'b0, 2'd1);

        // Signed vs unsigned compares with RS1=-1, RS2=1
        drive(1'b1, 2'b01, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h10);
        step(); chk_state("blt", 32'h78, 1'b1, 1'b1, 1'b0, 2'd2);
        drive(1'b1, 2'b01, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h10);
        step(); chk_state("bltu", 32'h7C, 1'b0, 1'b0, 1'b0, 2'd2);
        drive(1'b1, 2'b01, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'h10);
        step(); chk_state("bge", 32'h80, 1'b0, 1'b0, 1'b0, 2'd2);
        drive(1'b1, 2'b01, 3'b111, 32'hFFFF_FFFF, 32'd1, 32'h10);
        step(); chk_state("bgeu", 32'h90, 1'b1, 1'b1, 1'b0, 2'd3);
        drive(1'b1, 2'b01, 3'b010, 32'd7, 32'd7, 32'h10);
        step(); chk_state("f3_010", 32'h94, 1'b0, 1'b0, 1'b0, 2'd3);
        drive(1'b1, 2'b01, 3'b001, 32'd1, 32'd2, 32'hFFFF_FFEC);
        step(); chk_state("bne_sat", 32'h80, 1'b1, 1'b1, 1'b0, 2'd3);
        drive(1'b1, 2'b01, 3'b000, 32'd1, 32'd2, 32'h2);
        step(); chk_state("nt_misaligned", 32'h84, 1'b0, 1'b0, 1'b0, 2'd3);

        // jalr clears bit 0; LINK valid in the same cycle
        drive(1'b1, 2'b11, 3'b000, 32'h101, 32'd0, 32'h0);
        #1 chk("jalr.link", bus.LINK, 32'h88);
        step(); chk_state("jalr", 32'h100, 1'b1, 1'b1, 1'b0, 2'd3);

        // jal to misaligned target traps
        drive(1'b1, 2'b10, 3'b000, 32'd0, 32'd0, 32'h2);
        step(); chk_state("jal_trap", 32'h100, 1'b0, 1'b1, 1'b1, 2'd3);
        chk("jal_trap.epc", bus.EPC, 32'h100);
        chk("jal_trap.badaddr", bus.BADADDR, 32'h102);
        step(); chk_state("trap_hold", 32'h100, 1'b0, 1'b0, 1'b1, 2'd3);
        drive(1'b0, 2'b00, 3'b000, 32'd0, 32'd0, 32'd0);
        bus.STALL = 1'b1;
        bus.TRAP_ACK = 1'b1;
        step(); chk_state("trap_ack", 32'h104, 1'b0, 1'b0, 1'b0, 2'd3);
        bus.STALL = 1'b0;
        bus.TRAP_ACK = 1'b0;

        // jalr whose cleared target is still misaligned traps; ACK in RUN ignored
        drive(1'b1, 2'b11, 3'b000, 32'h103, 32'd0, 32'h0);
        step(); chk_state("jalr_trap", 32'h100, 1'b0, 1'b1, 1'b1, 2'd3);
        chk("jalr_trap.epc", bus.EPC, 32'h104);
        chk("jalr_trap.badaddr", bus.BADADDR, 32'h102);
        drive(1'b0, 2'b00, 3'b000, 32'd0, 32'd0, 32'd0);
        bus.TRAP_ACK = 1'b1;
        step(); chk_state("trap_ack2", 32'h104, 1'b0, 1'b0, 1'b0, 2'd3);
        step(); chk_state("ack_in_run", 32'h108, 1'b0, 1'b0, 1'b0, 2'd3);
        bus.TRAP_ACK = 1'b0;

        // Stall freezes a taken beq, then it redirects exactly once
        drive(1'b1, 2'b01, 3'b000, 32'd9, 32'd9, 32'h40);
        bus.STALL = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(); chk_state("stall", 32'h108, 1'b0, 1'b0, 1'b0, 2'd3);
        end
        bus.STALL = 1'b0;
        step(); chk_state("stall_release", 32'h148, 1'b1, 1'b1, 1'b0, 2'd3);
        drive(1'b0, 2'b00, 3'b000, 32'd0, 32'd0, 32'd0);
        step(); chk_state("post_release", 32'h14C, 1'b0, 1'b0, 1'b0, 2'd3);

        // Wrap-around
        drive(1'b1, 2'b10, 3'b000, 32'd0, 32'd0, 32'hFFFF_FEB0);
        step(); chk_state("jal_top", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 2'd3);
        chk("wrap.link", bus.LINK, 32'h0);
        drive(1'b0, 2'b00, 3'b000, 32'd0, 32'd0, 32'd0);
        step(); chk_state("wrap", 32'h0, 1'b0, 1'b0, 1'b0, 2'd3);

        // Async reset in the middle of a trap
        drive(1'b1, 2'b10, 3'b000, 32'd0, 32'd0, 32'h1);
        step(); chk_state("trap2", 32'h100, 1'b0, 1'b1, 1'b1, 2'd3);
        chk("trap2.badaddr", bus.BADADDR, 32'h1);
        drive(1'b0, 2'b00, 3'b000, 32'd0, 32'd0, 32'd0);
        #2 RST_N = 1'b0;
        #1;
        chk_state("mid_trap_reset", 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
        chk("mid_trap_reset.epc", bus.EPC, 32'h0);
        chk("mid_trap_reset.badaddr", bus.BADADDR, 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        step(); chk_state("after_reset", 32'h4, 1'b0, 1'b0, 1'b0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
